// File: rtl/reg_writeback_if.sv
// Bundle of the three unit result channels, the issue reservation, the scoreboard
// queries and the register-file write port seen by reg_writeback.
interface reg_writeback_if #(
  parameter int DATA_W = 64,
  parameter int RN_W   = 6
);
  logic              u0_valid, u1_valid, u2_valid;
  logic [RN_W-1:0]   u0_rn, u1_rn, u2_rn;
  logic [DATA_W-1:0] u0_data, u1_data, u2_data;
  logic              u0_ready, u1_ready, u2_ready;

  logic              iss_valid;
  logic [RN_W-1:0]   iss_rn;

  logic [RN_W-1:0]   q1_rn, q2_rn, qw_rn;
  logic              q1_busy, q2_busy, qw_busy;

  logic              w_en;
  logic [RN_W-1:0]   w_rn;
  logic [DATA_W-1:0] w_data;
  logic              sb_err;

  modport master (
    output u0_valid, u1_valid, u2_valid,
    output u0_rn, u1_rn, u2_rn,
    output u0_data, u1_data, u2_data,
    input  u0_ready, u1_ready, u2_ready,
    output iss_valid, iss_rn,
    output q1_rn, q2_rn, qw_rn,
    input  q1_busy, q2_busy, qw_busy,
    input  w_en, w_rn, w_data, sb_err
  );

  modport slave (
    input  u0_valid, u1_valid, u2_valid,
    input  u0_rn, u1_rn, u2_rn,
    input  u0_data, u1_data, u2_data,
    output u0_ready, u1_ready, u2_ready,
    input  iss_valid, iss_rn,
    input  q1_rn, q2_rn, qw_rn,
    output q1_busy, q2_busy, qw_busy,
    output w_en, w_rn, w_data, sb_err
  );
endinterface

// File: rtl/reg_writeback.sv
// Writeback arbiter for the Raisin64 register file: one holding register per unit,
// round-robin onto a registered write port, plus a pending-write scoreboard.
module reg_writeback #(
  parameter int DATA_W = 64,
  parameter int RN_W   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_writeback_if.slave bus
);
  localparam int NU   = 3;
  localparam int NQ   = 3;
  localparam int NREG = 1 << RN_W;

  logic [NU-1:0]     u_valid;
  logic [NU-1:0]     u_ready;
  logic [NU-1:0]     u_load;
  logic [RN_W-1:0]   u_rn   [NU];
  logic [DATA_W-1:0] u_data [NU];

  logic [RN_W-1:0]   q_rn [NQ];
  logic [NQ-1:0]     q_busy;

  logic [NU-1:0]     hold_v_q, hold_v_d;
  logic [RN_W-1:0]   hold_rn_q   [NU];
  logic [DATA_W-1:0] hold_data_q [NU];

  logic [1:0]        last_q, last_d;
  logic [1:0]        order [NU];
  logic [NU-1:0]     grant;
  logic [1:0]        grant_idx;
  logic              grant_any;

  logic              w_en_q;
  logic [RN_W-1:0]   w_rn_q;
  logic [DATA_W-1:0] w_data_q;

  logic [NREG-1:0]   pending_q, pending_d;
  logic              sb_err_q, sb_err_d;
  logic              iss_set;
  logic              iss_conflict;

  assign u_valid   = {bus.u2_valid, bus.u1_valid, bus.u0_valid};
  assign u_rn[0]   = bus.u0_rn;
  assign u_rn[1]   = bus.u1_rn;
  assign u_rn[2]   = bus.u2_rn;
  assign u_data[0] = bus.u0_data;
  assign u_data[1] = bus.u1_data;
  assign u_data[2] = bus.u2_data;

  assign bus.u0_ready = u_ready[0];
  assign bus.u1_ready = u_ready[1];
  assign bus.u2_ready = u_ready[2];

  assign q_rn[0] = bus.q1_rn;
  assign q_rn[1] = bus.q2_rn;
  assign q_rn[2] = bus.qw_rn;

  assign bus.q1_busy = q_busy[0];
  assign bus.q2_busy = q_busy[1];
  assign bus.qw_busy = q_busy[2];

  assign bus.w_en   = w_en_q;
  assign bus.w_rn   = w_rn_q;
  assign bus.w_data = w_data_q;
  assign bus.sb_err = sb_err_q;

  // Unit index examined k-th in this cycle's search, starting after last_q.
  function automatic logic [1:0] rr_slot(input logic [1:0] last, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, last} + 3'd1 + {1'b0, k};
    if (s >= 3'd6)
      s = s - 3'd6;
    else if (s >= 3'd3)
      s = s - 3'd3;
    return s[1:0];
  endfunction

  for (genvar gi = 0; gi < NU; gi++) begin : g_order
    assign order[gi] = rr_slot(last_q, 2'(gi));
  end

  // Walk the search order backwards so the earliest valid slot overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    for (int k = NU - 1; k >= 0; k--) begin
      if (hold_v_q[order[k]]) begin
        grant            = '0;
        grant[order[k]]  = 1'b1;
        grant_idx        = order[k];
      end
    end
  end

  assign grant_any = |grant;
  assign last_d    = grant_any ? grant_idx : last_q;

  // A unit may refill its holding register in the same cycle it is drained.
  for (genvar gi = 0; gi < NU; gi++) begin : g_unit
    assign u_ready[gi]  = ~hold_v_q[gi] | grant[gi];
    assign u_load[gi]   = u_valid[gi] & u_ready[gi] & (u_rn[gi] != '0);
    assign hold_v_d[gi] = u_load[gi] | (hold_v_q[gi] & ~grant[gi]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v_q <= '0;
      for (int i = 0; i < NU; i++) begin
        hold_rn_q[i]   <= '0;
        hold_data_q[i] <= '0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      for (int i = 0; i < NU; i++) begin
        if (u_load[i]) begin
          hold_rn_q[i]   <= u_rn[i];
          hold_data_q[i] <= u_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_q   <= 1'b0;
      w_rn_q   <= '0;
      w_data_q <= '0;
      last_q   <= 2'd2;
    end else begin
      w_en_q <= grant_any;
      last_q <= last_d;
      if (grant_any) begin
        w_rn_q   <= hold_rn_q[grant_idx];
        w_data_q <= hold_data_q[grant_idx];
      end
    end
  end

  // A register being written this cycle already reads free, so re-reserving it is legal.
  assign iss_set      = bus.iss_valid & (bus.iss_rn != '0);
  assign iss_conflict = iss_set & pending_q[bus.iss_rn] & ~(w_en_q & (w_rn_q == bus.iss_rn));
  assign sb_err_d     = sb_err_q | iss_conflict;

  always_comb begin
    pending_d = pending_q;
    if (w_en_q)
      pending_d[w_rn_q] = 1'b0;
    if (iss_set)
      pending_d[bus.iss_rn] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  for (genvar gi = 0; gi < NQ; gi++) begin : g_query
    assign q_busy[gi] = pending_q[q_rn[gi]] & ~(w_en_q & (w_rn_q == q_rn[gi]));
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table, directed corner sequences
// and a randomized run against a cycle-level reference model.
module tb_reg_writeback;
  localparam int DATA_W = 64;
  localparam int RN_W   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_if #(.DATA_W(DATA_W), .RN_W(RN_W)) bus ();

  reg_writeback #(.DATA_W(DATA_W), .RN_W(RN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          unit;
    logic [5:0]  rn;
    logic [63:0] data;
    bit          exp_wen;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_unit(input int u, input logic v, input logic [5:0] rn, input logic [63:0] d);
    case (u)
      0: begin bus.u0_valid = v; bus.u0_rn = rn; bus.u0_data = d; end
      1: begin bus.u1_valid = v; bus.u1_rn = rn; bus.u1_data = d; end
      default: begin bus.u2_valid = v; bus.u2_rn = rn; bus.u2_data = d; end
    endcase
  endtask

  function automatic logic rdy(input int u);
    case (u)
      0: return bus.u0_ready;
      1: return bus.u1_ready;
      default: return bus.u2_ready;
    endcase
  endfunction

  function automatic logic qbusy(input int qi);
    case (qi)
      0: return bus.q1_busy;
      1: return bus.q2_busy;
      default: return bus.qw_busy;
    endcase
  endfunction

  task automatic idle();
    for (int u = 0; u < 3; u++) set_unit(u, 1'b0, 6'd0, 64'd0);
    bus.iss_valid = 1'b0;
    bus.iss_rn    = 6'd0;
    bus.q1_rn     = 6'd0;
    bus.q2_rn     = 6'd0;
    bus.qw_rn     = 6'd0;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_state(input string tag);
    to_neg();
    chk({tag, "_w_en"}, 64'(bus.w_en), 64'd0);
    for (int u = 0; u < 3; u++) chk({tag, "_ready"}, 64'(rdy(u)), 64'd1);
    for (int qi = 0; qi < 3; qi++) chk({tag, "_busy"}, 64'(qbusy(qi)), 64'd0);
    chk({tag, "_sb_err"}, 64'(bus.sb_err), 64'd0);
  endtask

  // Reference model state for the randomized run
  bit          m_hv    [3];
  logic [5:0]  m_hrn   [3];
  logic [63:0] m_hd    [3];
  int          m_last;
  bit [63:0]   m_pend;
  bit          m_err;
  bit          m_wen;
  logic [5:0]  m_wrn;
  logic [63:0] m_wdata;

  initial begin
    int          acc [3];
    int          wr  [3];
    int          eu;
    int          g;
    bit          rv  [3];
    logic [5:0]  rr  [3];
    logic [63:0] rd  [3];
    bit          er  [3];
    bit          iv;
    logic [5:0]  ir;
    logic [5:0]  qr  [3];

    vecs[0] = '{unit: 0, rn: 6'd5,  data: 64'h1234,                exp_wen: 1'b1};
    vecs[1] = '{unit: 1, rn: 6'd63, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_wen: 1'b1};
    vecs[2] = '{unit: 2, rn: 6'd0,  data: 64'hDEAD,                exp_wen: 1'b0};
    vecs[3] = '{unit: 2, rn: 6'd1,  data: 64'h8000_0000_0000_0001, exp_wen: 1'b1};
    vecs[4] = '{unit: 1, rn: 6'd0,  data: 64'hBEEF,                exp_wen: 1'b0};
    vecs[5] = '{unit: 0, rn: 6'd42, data: 64'h0,                   exp_wen: 1'b1};

    // Reset state
    do_reset();
    to_neg();
    chk("rst_w_rn", 64'(bus.w_rn), 64'd0);
    chk("rst_w_data", bus.w_data, 64'd0);
    chk_idle_state("rst");
    next_cyc();

    // Single results from idle: accepted at t, written at t+2, r0 dropped
    for (int i = 0; i < 6; i++) begin
      idle();
      set_unit(vecs[i].unit, 1'b1, vecs[i].rn, vecs[i].data);
      to_neg();
      chk("vec_ready", 64'(rdy(vecs[i].unit)), 64'd1);
      next_cyc();
      idle();
      to_neg();
      chk("vec_wen_t1", 64'(bus.w_en), 64'd0);
      next_cyc();
      to_neg();
      chk("vec_wen_t2", 64'(bus.w_en), 64'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        chk("vec_w_rn", 64'(bus.w_rn), 64'(vecs[i].rn));
        chk("vec_w_data", bus.w_data, vecs[i].data);
      end
      next_cyc();
      to_neg();
      chk("vec_wen_t3", 64'(bus.w_en), 64'd0);
      $display("vec %0d: unit %0d rn %0d data 0x%0h write_expected %0d", i, vecs[i].unit,
               vecs[i].rn, vecs[i].data, vecs[i].exp_wen);
      next_cyc();
    end

    // Reservation of r7 cleared by a u1 write; busy drops in the write cycle
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd7;
    bus.q1_rn     = 6'd7;
    to_neg();
    chk("sb_before_set", 64'(bus.q1_busy), 64'd0);
    next_cyc();
    bus.iss_valid = 1'b0;
    to_neg();
    chk("sb_set", 64'(bus.q1_busy), 64'd1);
    next_cyc();
    set_unit(1, 1'b1, 6'd7, 64'h7777);
    to_neg();
    chk("sb_busy_t0", 64'(bus.q1_busy), 64'd1);
    next_cyc();
    set_unit(1, 1'b0, 6'd0, 64'd0);
    to_neg();
    chk("sb_busy_t1", 64'(bus.q1_busy), 64'd1);
    next_cyc();
    to_neg();
    chk("sb_w_en_t2", 64'(bus.w_en), 64'd1);
    chk("sb_w_rn_t2", 64'(bus.w_rn), 64'd7);
    chk("sb_busy_t2", 64'(bus.q1_busy), 64'd0);
    next_cyc();
    to_neg();
    chk("sb_busy_t3", 64'(bus.q1_busy), 64'd0);
    $display("scoreboard r7: reserve, write, release");
    // Reserving r0 never marks anything pending
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd0;
    bus.q2_rn     = 6'd0;
    next_cyc();
    bus.iss_valid = 1'b0;
    to_neg();
    chk("sb_r0_busy", 64'(bus.q2_busy), 64'd0);
    chk("sb_r0_err", 64'(bus.sb_err), 64'd0);
    next_cyc();

    // All units streaming r1/r2/r3 from reset: strict rotation, nothing lost
    do_reset();
    for (int u = 0; u < 3; u++) begin acc[u] = 0; wr[u] = 0; end
    for (int c = 0; c < 15; c++) begin
      for (int u = 0; u < 3; u++) set_unit(u, 1'b1, 6'(u + 1), {32'(u), 32'(acc[u])});
      to_neg();
      for (int u = 0; u < 3; u++) begin
        chk("rr_ready", 64'(rdy(u)), (c == 0) ? 64'd1 : 64'(u == (c - 1) % 3));
        if (rdy(u)) acc[u]++;
      end
      chk("rr_w_en", 64'(bus.w_en), 64'(c >= 2));
      if (c >= 2) begin
        eu = (c - 2) % 3;
        chk("rr_w_rn", 64'(bus.w_rn), 64'(eu + 1));
        chk("rr_w_data", bus.w_data, {32'(eu), 32'(wr[eu])});
        $display("rr cycle %0d: write r%0d data 0x%0h", c, bus.w_rn, bus.w_data);
        wr[eu]++;
      end
      next_cyc();
    end

    // Reserve r9 in the same cycle r9 is written: reservation survives, no error
    do_reset();
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd9;
    next_cyc();
    idle();
    set_unit(0, 1'b1, 6'd9, 64'h9999);
    next_cyc();
    idle();
    next_cyc();
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd9;
    to_neg();
    chk("same_w_en", 64'(bus.w_en), 64'd1);
    chk("same_w_rn", 64'(bus.w_rn), 64'd9);
    next_cyc();
    idle();
    bus.q1_rn = 6'd9;
    to_neg();
    chk("same_busy", 64'(bus.q1_busy), 64'd1);
    chk("same_err", 64'(bus.sb_err), 64'd0);
    $display("same-edge set/clear r9 checked");
    // Double reservation of r4 raises a sticky error
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd4;
    next_cyc();
    bus.qw_rn = 6'd4;
    to_neg();
    chk("dup_qw_busy", 64'(bus.qw_busy), 64'd1);
    chk("dup_err_before", 64'(bus.sb_err), 64'd0);
    next_cyc();
    bus.iss_valid = 1'b0;
    to_neg();
    chk("dup_err", 64'(bus.sb_err), 64'd1);
    for (int i = 0; i < 3; i++) next_cyc();
    to_neg();
    chk("dup_err_sticky", 64'(bus.sb_err), 64'd1);
    $display("double reservation r4 checked");
    next_cyc();

    // Reset while u0/u1 hold results and r3 is pending
    do_reset();
    set_unit(0, 1'b1, 6'd10, 64'hA0);
    set_unit(1, 1'b1, 6'd11, 64'hB0);
    bus.iss_valid = 1'b1;
    bus.iss_rn    = 6'd3;
    next_cyc();
    idle();
    bus.q1_rn = 6'd3;
    to_neg();
    chk("mid_busy_pre", 64'(bus.q1_busy), 64'd1);
    chk("mid_u1_held", 64'(bus.u1_ready), 64'd0);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    to_neg();
    chk("mid_busy_post", 64'(bus.q1_busy), 64'd0);
    chk_idle_state("mid");
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      to_neg();
      chk("mid_no_stale", 64'(bus.w_en), 64'd0);
    end
    $display("mid-operation reset checked");
    next_cyc();

    // Randomized traffic against the reference model
    do_reset();
    for (int u = 0; u < 3; u++) begin m_hv[u] = 1'b0; m_hrn[u] = '0; m_hd[u] = '0; end
    m_last = 2; m_pend = '0; m_err = 1'b0; m_wen = 1'b0; m_wrn = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int u = 0; u < 3; u++) begin
        rv[u] = ($urandom_range(0, 99) < 60);
        rr[u] = 6'($urandom_range(0, 15));
        rd[u] = {$urandom, $urandom};
        set_unit(u, rv[u], rr[u], rd[u]);
      end
      iv = ($urandom_range(0, 3) == 0);
      ir = 6'($urandom_range(0, 15));
      for (int qi = 0; qi < 3; qi++) qr[qi] = 6'($urandom_range(0, 15));
      bus.iss_valid = iv;
      bus.iss_rn    = ir;
      bus.q1_rn     = qr[0];
      bus.q2_rn     = qr[1];
      bus.qw_rn     = qr[2];

      g = -1;
      for (int off = 1; off <= 3; off++)
        if (g < 0 && m_hv[(m_last + off) % 3]) g = (m_last + off) % 3;
      for (int u = 0; u < 3; u++) er[u] = !m_hv[u] || (g == u);

      to_neg();
      for (int u = 0; u < 3; u++) chk("rand_ready", 64'(rdy(u)), 64'(er[u]));
      for (int qi = 0; qi < 3; qi++)
        chk("rand_busy", 64'(qbusy(qi)), 64'(m_pend[qr[qi]] && !(m_wen && m_wrn == qr[qi])));
      chk("rand_w_en", 64'(bus.w_en), 64'(m_wen));
      if (m_wen) begin
        chk("rand_w_rn", 64'(bus.w_rn), 64'(m_wrn));
        chk("rand_w_data", bus.w_data, m_wdata);
      end
      chk("rand_sb_err", 64'(bus.sb_err), 64'(m_err));

      if (iv && ir != 0 && m_pend[ir] && !(m_wen && m_wrn == ir)) m_err = 1'b1;
      if (m_wen) m_pend[m_wrn] = 1'b0;
      if (iv && ir != 0) m_pend[ir] = 1'b1;
      m_wen = (g >= 0);
      if (g >= 0) begin
        m_wrn   = m_hrn[g];
        m_wdata = m_hd[g];
        m_hv[g] = 1'b0;
        m_last  = g;
      end
      for (int u = 0; u < 3; u++) begin
        if (rv[u] && er[u] && rr[u] != 0) begin
          m_hv[u]  = 1'b1;
          m_hrn[u] = rr[u];
          m_hd[u]  = rd[u];
        end
      end
      next_cyc();
    end
    $display("random run: 400 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
